// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Brief    : Sprite DMA engine. Halts the CPU and copies one page to the OAM data port.
// Revision : 1.0
// ============================================================================
module oam_dma #(
   parameter logic [15:0] TRIG_ADDR = 16'h4014,
   parameter logic [15:0] OAM_ADDR  = 16'h2004,
   parameter int          LEN       = 256
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] addr,
   input  logic        rw,
   input  logic [7:0]  data_in,
   output logic        rdy,
   output logic        dma_oe,
   output logic [15:0] dma_addr,
   output logic        dma_rw,
   output logic [7:0]  dma_data,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   state_t      state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic        odd_q, odd_d;
   logic        rdy_q, rdy_d;
   logic        dma_oe_q, dma_oe_d;
   logic [15:0] dma_addr_q, dma_addr_d;
   logic        dma_rw_q, dma_rw_d;
   logic [7:0]  dma_data_q, dma_data_d;
   logic        busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      idx_d      = idx_q;
      odd_d      = ~odd_q;
      dma_data_d = dma_data_q;

      case (state_q)
         S_IDLE: begin
            if ((addr == TRIG_ADDR) && !rw) begin
               page_d  = data_in;
               idx_d   = 8'd0;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            // A CPU write cycle cannot be stalled; wait for a read to take the halt.
            // odd_q=1 now means the next cycle is even and may carry a DMA read.
            if (rw) begin
               state_d = odd_q ? S_READ : S_ALIGN;
            end
         end
         S_ALIGN: begin
            state_d = S_READ;
         end
         S_READ: begin
            dma_data_d = data_in;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == LAST_IDX) ? S_IDLE : S_READ;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are precomputed from the next state so the bus is registered.
      rdy_d    = (state_d == S_IDLE);
      busy_d   = (state_d != S_IDLE);
      dma_oe_d = (state_d == S_READ) || (state_d == S_WRITE);
      dma_rw_d = (state_d != S_WRITE);
      if (state_d == S_READ) begin
         dma_addr_d = {page_d, idx_d};
      end else if (state_d == S_WRITE) begin
         dma_addr_d = OAM_ADDR;
      end else begin
         dma_addr_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= S_IDLE;
         page_q     <= 8'd0;
         idx_q      <= 8'd0;
         odd_q      <= 1'b0;
         rdy_q      <= 1'b1;
         dma_oe_q   <= 1'b0;
         dma_addr_q <= 16'h0000;
         dma_rw_q   <= 1'b1;
         dma_data_q <= 8'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         idx_q      <= idx_d;
         odd_q      <= odd_d;
         rdy_q      <= rdy_d;
         dma_oe_q   <= dma_oe_d;
         dma_addr_q <= dma_addr_d;
         dma_rw_q   <= dma_rw_d;
         dma_data_q <= dma_data_d;
         busy_q     <= busy_d;
      end
   end

   assign rdy      = rdy_q;
   assign dma_oe   = dma_oe_q;
   assign dma_addr = dma_addr_q;
   assign dma_rw   = dma_rw_q;
   assign dma_data = dma_data_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma
// Brief    : Self-checking bench for oam_dma against a transfer-level model.
// Revision : 1.0
// ============================================================================
module tb_oam_dma;
   localparam int LEN = 256;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        rw = 1'b1;
   logic [7:0]  cpu_data = 8'h00;
   logic [7:0]  data_in;
   logic        rdy, dma_oe, dma_rw, busy;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data;

   int total = 0;
   int bad = 0;

   oam_dma dut (
      .clk(clk), .n_reset(n_reset), .addr(addr), .rw(rw), .data_in(data_in),
      .rdy(rdy), .dma_oe(dma_oe), .dma_addr(dma_addr), .dma_rw(dma_rw),
      .dma_data(dma_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Page $02 holds i^$5A; other pages are offset so a wrong page shows in the data.
   function automatic logic [7:0] ram_byte(input logic [15:0] a);
      return (a[7:0] ^ 8'h5A) + (a[15:8] - 8'h02);
   endfunction

   assign data_in = (dma_oe && dma_rw) ? ram_byte(dma_addr) : cpu_data;

   logic [31:0] cyc;
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   logic [15:0] rd_a[$];
   logic        rd_p[$];
   logic [15:0] wr_a[$];
   logic [7:0]  wr_d[$];
   logic        wr_p[$];
   int low_cnt = 0, stall_cnt = 0, inv_bad = 0;

   always @(negedge clk) begin
      if (n_reset) begin
         if (!rdy) low_cnt++;
         if (!rdy && !dma_oe) stall_cnt++;
         if (dma_oe && dma_rw) begin
            rd_a.push_back(dma_addr);
            rd_p.push_back(cyc[0]);
         end
         if (dma_oe && !dma_rw) begin
            wr_a.push_back(dma_addr);
            wr_d.push_back(dma_data);
            wr_p.push_back(cyc[0]);
         end
         if (!dma_oe && (dma_addr != 16'h0000 || !dma_rw)) inv_bad++;
         if (busy == rdy) inv_bad++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // par: 0/1 forces the trigger cycle parity, 2 takes whatever comes.
   task automatic run_transfer(input logic [7:0] page, input int extra, input int par,
                               input int retrig_at);
      int lo0, st0, r0, w0, ib0, n, exp_align, exp_low, ea, ed, ep, nr, nw;
      logic p;
      bit rt_done;
      rt_done = 0;
      @(negedge clk);
      #1;
      if (par != 2) while (cyc[0] != par[0]) begin @(negedge clk); #1; end
      lo0 = low_cnt; st0 = stall_cnt; r0 = rd_a.size(); w0 = wr_a.size(); ib0 = inv_bad;
      p = cyc[0];
      addr = 16'h4014; rw = 1'b0; cpu_data = page;
      @(negedge clk);
      #1;
      addr = 16'h0005; rw = (extra == 0); cpu_data = 8'hEE;
      for (int k = 1; k <= extra; k++) begin
         @(negedge clk);
         #1;
         if (k == extra) rw = 1'b1;
      end
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
         if (rt_done && !rw) begin
            addr = 16'h0005; rw = 1'b1;
         end else if (retrig_at >= 0 && !rt_done && (wr_a.size() - w0) == retrig_at) begin
            addr = 16'h4014; rw = 1'b0; cpu_data = 8'h07; rt_done = 1;
         end
      end
      addr = 16'h0005; rw = 1'b1;
      chk("transfer_timeout", 32'(n < 3000), 32'd1);

      exp_align = (int'(p) + extra) % 2;
      exp_low   = 1 + extra + exp_align + 2 * LEN;
      chk("rdy_low_cycles", 32'(low_cnt - lo0), 32'(exp_low));
      chk("non_owned_halt_cycles", 32'(stall_cnt - st0), 32'(1 + extra + exp_align));
      nr = rd_a.size() - r0;
      nw = wr_a.size() - w0;
      chk("read_count", 32'(nr), 32'(LEN));
      chk("write_count", 32'(nw), 32'(LEN));
      ea = 0; ed = 0; ep = 0;
      for (int i = 0; i < LEN; i++) begin
         if (i < nr) begin
            if (rd_a[r0 + i] !== {page, 8'(i)}) ea++;
            if (rd_p[r0 + i] !== 1'b0) ep++;
         end
         if (i < nw) begin
            if (wr_a[w0 + i] !== 16'h2004) ea++;
            if (wr_d[w0 + i] !== ram_byte({page, 8'(i)})) ed++;
            if (wr_p[w0 + i] !== 1'b1) ep++;
         end
      end
      chk("bus_addresses", 32'(ea), 32'd0);
      chk("written_bytes", 32'(ed), 32'd0);
      chk("cycle_parity", 32'(ep), 32'd0);
      chk("idle_bus_and_busy", 32'(inv_bad - ib0), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      chk("single_transfer", {31'd0, busy} + 32'(rd_a.size() - r0), 32'(LEN));
   endtask

   typedef struct {
      logic [15:0] a;
      logic        rw;
      logic [7:0]  d;
      logic [2:0]  exp;  // {rdy, busy, dma_oe}
   } vec_t;

   vec_t vecs[5];

   initial begin
      int w0, w1, n;
      logic [7:0] pg;
      vecs[0] = '{16'h4015, 1'b0, 8'h02, 3'b100};
      vecs[1] = '{16'h4014, 1'b1, 8'h02, 3'b100};
      vecs[2] = '{16'h6014, 1'b0, 8'h02, 3'b100};
      vecs[3] = '{16'h0014, 1'b0, 8'h03, 3'b100};
      vecs[4] = '{16'h4004, 1'b0, 8'h04, 3'b100};

      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", {rdy, dma_oe, dma_addr, dma_rw, dma_data, busy},
          {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
      n_reset = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_after_reset", {rdy, dma_oe, dma_addr, dma_rw, dma_data, busy},
          {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});

      for (int i = 0; i < 5; i++) begin
         addr = vecs[i].a; rw = vecs[i].rw; cpu_data = vecs[i].d;
         @(negedge clk);
         #1;
         addr = 16'h0005; rw = 1'b1;
         @(negedge clk);
         #1;
         chk($sformatf("no_trigger_%0d", i), {29'd0, rdy, busy, dma_oe}, {29'd0, vecs[i].exp});
      end

      run_transfer(8'h02, 0, 0, -1);
      run_transfer(8'h02, 0, 1, -1);
      run_transfer(8'h02, 2, 0, -1);
      run_transfer(8'h03, 0, 2, 100);
      run_transfer(8'hFF, 1, 2, -1);

      // Reset in the middle of a transfer from page $04.
      w0 = wr_a.size();
      @(negedge clk);
      #1;
      addr = 16'h4014; rw = 1'b0; cpu_data = 8'h04;
      @(negedge clk);
      #1;
      addr = 16'h0005; rw = 1'b1;
      n = 0;
      while ((wr_a.size() - w0) < 40 && n < 2000) begin @(negedge clk); #1; n++; end
      chk("reach_byte_40", 32'(wr_a.size() - w0), 32'd40);
      #2 n_reset = 1'b0;
      #1;
      chk("async_reset_outputs", {rdy, dma_oe, dma_addr, dma_rw, dma_data, busy},
          {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
      w1 = wr_a.size();
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("abandoned_after_reset", 32'(wr_a.size() - w1) + {31'd0, busy}, 32'd0);
      run_transfer(8'h05, 0, 2, -1);

      for (int r = 0; r < 5; r++) begin
         pg = 8'($urandom);
         run_transfer(pg, int'($urandom_range(0, 3)), 2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
